// File: rtl/mmu_rx_frm_acct.sv
// Rx frame accounting: derives per-frame byte length on the write side, chunked
// line decrements on the read side, and tracks FIFO line occupancy with sticky errors.
module mmu_rx_frm_acct #(
  parameter int          DEC_CHUNK = 16,
  parameter logic [9:0]  WLINE_MAX = 10'd1023
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        wr_vld,
  input  logic        wr_sop,
  input  logic        wr_eop,
  input  logic [5:0]  wr_mty,
  input  logic        rd_vld,
  input  logic        rd_eop,
  input  logic        err_clr,
  output logic [9:0]  bucket_wline,
  output logic        bucket_inc_wr,
  output logic [13:0] bucket_inc_wdata,
  output logic        bucket_dec_wr,
  output logic [9:0]  bucket_dec_wdata,
  output logic        bucket_dec_wend,
  output logic [3:0]  acct_err
);

  localparam logic [4:0] CHUNK5 = 5'(DEC_CHUNK);

  typedef enum logic {W_IDLE, W_FRM} wstate_e;

  wstate_e     wstate_q, wstate_d;
  logic [8:0]  beat_cnt_q, beat_cnt_d;
  logic        inc_wr_q, inc_wr_d;
  logic [13:0] inc_data_q, inc_data_d;
  logic [4:0]  chunk_q, chunk_d, chunk_nxt;
  logic        dec_wr_q, dec_wr_d;
  logic [9:0]  dec_data_q, dec_data_d;
  logic        dec_wend_q, dec_wend_d;
  logic [9:0]  wline_q, wline_d;
  logic [3:0]  err_q, err_d, err_set;
  logic [9:0]  beats_now;
  logic [15:0] frm_len;

  always_comb begin
    wstate_d   = wstate_q;
    beat_cnt_d = beat_cnt_q;
    inc_wr_d   = 1'b0;
    inc_data_d = inc_data_q;
    err_set    = 4'd0;
    beats_now  = 10'd0;
    frm_len    = 16'd0;
    chunk_nxt  = chunk_q + 5'd1;
    chunk_d    = chunk_q;
    dec_wr_d   = 1'b0;
    dec_data_d = 10'd0;
    dec_wend_d = 1'b0;
    wline_d    = wline_q;

    // beats_now stays 0 for a stray beat outside a frame, which is not length-counted
    if (wr_vld) begin
      if (wr_sop) begin
        if (wstate_q == W_FRM) err_set[0] = 1'b1;
        beats_now = 10'd1;
      end else if (wstate_q == W_FRM) begin
        beats_now = {1'b0, beat_cnt_q} + 10'd1;
      end else begin
        err_set[1] = 1'b1;
      end

      if (beats_now != 10'd0) begin
        frm_len = {beats_now, 6'b0} - {10'd0, wr_mty};
        if (wr_eop) begin
          inc_wr_d   = 1'b1;
          wstate_d   = W_IDLE;
          beat_cnt_d = 9'd0;
          if (frm_len > 16'd16383) begin
            inc_data_d = 14'h3fff;
            err_set[2] = 1'b1;
          end else begin
            inc_data_d = frm_len[13:0];
          end
        end else begin
          wstate_d   = W_FRM;
          beat_cnt_d = (beats_now > 10'd256) ? 9'd256 : beats_now[8:0];
        end
      end
    end

    // An eop on a chunk boundary folds into the same single pulse
    if (rd_vld) begin
      if (rd_eop || (chunk_nxt == CHUNK5)) begin
        dec_wr_d   = 1'b1;
        dec_data_d = {5'd0, chunk_nxt};
        dec_wend_d = rd_eop;
        chunk_d    = 5'd0;
      end else begin
        chunk_d    = chunk_nxt;
      end
    end

    if (wr_vld && !rd_vld) begin
      if (wline_q >= WLINE_MAX) begin
        wline_d    = WLINE_MAX;
        err_set[3] = 1'b1;
      end else begin
        wline_d    = wline_q + 10'd1;
      end
    end else if (rd_vld && !wr_vld) begin
      if (wline_q == 10'd0) err_set[3] = 1'b1;
      else                  wline_d    = wline_q - 10'd1;
    end

    err_d = (err_clr ? 4'd0 : err_q) | err_set;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q   <= W_IDLE;
      beat_cnt_q <= 9'd0;
      inc_wr_q   <= 1'b0;
      inc_data_q <= 14'd0;
      chunk_q    <= 5'd0;
      dec_wr_q   <= 1'b0;
      dec_data_q <= 10'd0;
      dec_wend_q <= 1'b0;
      wline_q    <= 10'd0;
      err_q      <= 4'd0;
    end else begin
      wstate_q   <= wstate_d;
      beat_cnt_q <= beat_cnt_d;
      inc_wr_q   <= inc_wr_d;
      inc_data_q <= inc_data_d;
      chunk_q    <= chunk_d;
      dec_wr_q   <= dec_wr_d;
      dec_data_q <= dec_data_d;
      dec_wend_q <= dec_wend_d;
      wline_q    <= wline_d;
      err_q      <= err_d;
    end
  end

  assign bucket_wline     = wline_q;
  assign bucket_inc_wr    = inc_wr_q;
  assign bucket_inc_wdata = inc_data_q;
  assign bucket_dec_wr    = dec_wr_q;
  assign bucket_dec_wdata = dec_data_q;
  assign bucket_dec_wend  = dec_wend_q;
  assign acct_err         = err_q;

endmodule

// File: doc/mmu_rx_frm_acct.md
MMU_RX_FRM_ACCT -- requirements
Module: mmu_rx_frm_acct

Interface
REQ-001 Parameter: DEC_CHUNK, default 16, read beats per bucket_dec_wr pulse (legal 1..31).
REQ-002 Parameter: WLINE_MAX, default 10'd1023, saturation ceiling of bucket_wline.
REQ-003 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 wr_vld  in  1  one 64-byte beat written into the rx data FIFO this cycle.
REQ-006 wr_sop / wr_eop  in  1 each  first / last beat of the frame, qualified by wr_vld.
REQ-007 wr_mty  in  6  empty bytes in the eop beat; ignored when wr_eop=0.
REQ-008 rd_vld  in  1  one beat read out of the rx data FIFO this cycle.
REQ-009 rd_eop  in  1  last beat of the frame being read, qualified by rd_vld.
REQ-010 err_clr  in  1  single-cycle pulse that clears acct_err.
REQ-011 bucket_wline  out  10  FIFO lines currently occupied.
REQ-012 bucket_inc_wr / bucket_inc_wdata  out  1 / 14  frame-length increment strobe and byte length.
REQ-013 bucket_dec_wr / bucket_dec_wdata / bucket_dec_wend  out  1 / 10 / 1  decrement strobe, line count, end-of-frame flag.
REQ-014 acct_err  out  4  sticky errors: [0] sop in frame, [1] beat with no sop, [2] length overflow, [3] wline under/overflow.

Function
REQ-015 Write FSM states W_IDLE, W_FRM: W_IDLE->W_FRM on wr_vld&wr_sop&!wr_eop; W_FRM->W_IDLE on wr_vld&wr_eop.
REQ-016 Single-beat frame (wr_sop&wr_eop): stays in W_IDLE and issues the increment.
REQ-017 Beat counter counts wr_vld beats of the current frame, 9 bits, saturating at 256.
REQ-018 Frame length = beats*64 - wr_mty, computed at the eop beat.
REQ-019 bucket_inc_wr is a one-cycle pulse, registered, in the cycle after the eop beat; bucket_inc_wdata is valid with it and holds its value otherwise.
REQ-020 Length > 16383 (beats >= 257, or 256 beats with mty=0): inc_wdata=14'h3fff and acct_err[2] is set.
REQ-021 wr_sop in W_FRM: set acct_err[0]; discard the partial count; restart counting with this beat as beat 1.
REQ-022 wr_vld without wr_sop in W_IDLE: set acct_err[1]; beat is not length-counted; FSM stays in W_IDLE.
REQ-023 Read side keeps a 5-bit chunk counter of rd_vld beats.
REQ-024 Chunk full: when a non-eop rd beat brings the count to DEC_CHUNK, next cycle dec_wr=1, dec_wdata=DEC_CHUNK, dec_wend=0; counter clears.
REQ-025 On an rd_eop beat, next cycle dec_wr=1, dec_wdata=count including this beat, dec_wend=1; counter clears.
REQ-026 If eop lands exactly on a chunk boundary, exactly one pulse is emitted: dec_wdata=DEC_CHUNK, dec_wend=1.
REQ-027 bucket_dec_wdata upper bits are zero; dec outputs are 0 except during a pulse.
REQ-028 bucket_wline, registered, updates one cycle after the beat: +1 on wr_vld only, -1 on rd_vld only, unchanged on both or neither.
REQ-029 bucket_wline saturates at WLINE_MAX on overflow and at 0 on underflow; either event sets acct_err[3].
REQ-030 acct_err bits are sticky.
REQ-031 err_clr zeroes acct_err next cycle; an error detected in the same cycle as err_clr wins and is set.
REQ-032 Write and read sides are independent; simultaneous events on both sides are processed in the same cycle.

Reset
REQ-033 While rst_n=0: FSM in W_IDLE; all counters 0; bucket_wline=0; inc_wr, dec_wr, dec_wend=0; inc_wdata, dec_wdata=0; acct_err=0.
REQ-034 Reset asserted mid-frame discards the partial frame; no increment or decrement pulse is emitted after rst_n rises.
REQ-035 First beats are accepted on the first rising edge of clk_sys with rst_n=1.

Verification
REQ-036 3-beat frame (sop, mid, eop with mty=10) -> one cycle after eop: inc_wr=1, inc_wdata=182; bucket_wline=3.
REQ-037 Single beat with sop&eop, mty=63 -> inc_wdata=1; acct_err stays 0.
REQ-038 Read 40-beat frame, DEC_CHUNK=16 -> dec pulses of 16/0, 16/0, 8/1 (wdata/wend); then write 32 beats and read that 32-beat frame -> pulses 16/0, 16/1; wline falls by 32 over the read.
REQ-039 wr_vld&rd_vld every cycle for 100 cycles starting from wline=5 -> wline stays 5.
REQ-040 rd_vld with wline=0 -> wline stays 0, acct_err[3]=1; then err_clr pulse -> acct_err=0.
REQ-041 257-beat frame -> inc_wdata=16383, acct_err[2]=1; sop inside the frame -> acct_err[0]=1, new count starts at 1.
